bram_fifo_ctrl_1clk: RTL

//  Single-clock first-word-fall-through FIFO controller. It is the client that drives a

---
 rtl/fifo_pkg.sv | 17 +
 rtl/bram_fifo_ctrl_1clk_if.sv | 21 ++
 rtl/fifo_stage_reg.sv | 51 +++++
 rtl/bram_fifo_ctrl_1clk.sv | 132 +++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the BRAM-backed FWFT FIFO controller:
// read-latency range and circular pointer increment.
package fifo_pkg;

    localparam int DEL_MIN = 1;
    localparam int DEL_MAX = 2;

    function automatic bit del_ok(int d);
        return (d >= DEL_MIN) && (d <= DEL_MAX);
    endfunction

    // Wraps at dep-1, so dep need not be a power of two.
    function automatic int unsigned ptr_inc(int unsigned ptr, int unsigned dep);
        return (ptr >= dep - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/bram_fifo_ctrl_1clk_if.sv
// Valid/ready stream bundle for the FIFO write and read sides.
interface bram_fifo_ctrl_1clk_if #(
    parameter int DAT = 9
);
    logic           wr_vld;
    logic [DAT-1:0] wr_dat;
    logic           wr_rdy;
    logic           rd_vld;
    logic [DAT-1:0] rd_dat;
    logic           rd_rdy;

    modport master (
        output wr_vld, wr_dat, rd_rdy,
        input  wr_rdy, rd_vld, rd_dat
    );

    modport slave (
        input  wr_vld, wr_dat, rd_rdy,
        output wr_rdy, rd_vld, rd_dat
    );
endinterface

// File: rtl/fifo_stage_reg.sv
// Small register FIFO that stages RAM read data; head sits at entry 0.
module fifo_stage_reg
    import fifo_pkg::*;
#(
    parameter int N  = 2,
    parameter int W  = 9,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [CW-1:0] cnt,
    output logic [W-1:0]  head
);

    logic [W-1:0]  mem_q [N];
    logic [W-1:0]  mem_d [N];
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] idx;

    always_comb begin
        mem_d = mem_q;
        idx   = cnt_q;
        if (pop) begin
            for (int i = 0; i < N - 1; i++) mem_d[i] = mem_q[i+1];
            idx = cnt_q - CW'(1);
        end
        if (push) begin
            for (int i = 0; i < N; i++) begin
                if (CW'(i) == idx) mem_d[i] = din;
            end
        end
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) mem_q[i] <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign head = mem_q[0];

endmodule

// File: rtl/bram_fifo_ctrl_1clk.sv
// Single-clock FWFT FIFO controller driving a read-first TDP block RAM:
// writes on port A, prefetch reads on port B into a DEL+1 entry stage.
module bram_fifo_ctrl_1clk
    import fifo_pkg::*;
#(
    parameter int ADR  = 11,
    parameter int DAT  = 9,
    parameter int DEP  = 2048,
    parameter int DEL  = 1,
    parameter int AFUL = 2040,
    parameter int AEMP = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    bram_fifo_ctrl_1clk_if.slave  io,
    output logic [ADR:0]          level,
    output logic                  afull,
    output logic                  aempty,
    output logic                  ovf,
    output logic                  udf,
    input  logic                  clr_sticky,
    output logic [ADR-1:0]        ram_adra,
    output logic                  ram_wena,
    output logic                  ram_rena,
    output logic [DAT-1:0]        ram_wdaa,
    output logic [ADR-1:0]        ram_adrb,
    output logic                  ram_renb,
    input  logic [DAT-1:0]        ram_rdab
);

    localparam int LW  = ADR + 1;
    localparam int SN  = DEL + 1;
    localparam int SCW = $clog2(SN + 1);

    if (!del_ok(DEL)) begin : g_del_chk
        $error("bram_fifo_ctrl_1clk: DEL must be 1 or 2");
    end

    logic [ADR-1:0] wptr_q, wptr_d;
    logic [ADR-1:0] fptr_q, fptr_d;
    logic [LW-1:0]  level_q, level_d;
    logic [LW-1:0]  ram_cnt_q, ram_cnt_d;
    logic [DEL-1:0] inf_q, inf_d;
    logic           wr_rdy_q, wr_rdy_d;
    logic           afull_q, afull_d;
    logic           aempty_q, aempty_d;
    logic           ovf_q, ovf_d;
    logic           udf_q, udf_d;

    logic [SCW-1:0] stg_cnt;
    logic [DAT-1:0] stg_head;
    logic           rd_vld, wr_acc, pop, push, fetch;
    logic [2:0]     occ;

    always_comb begin
        rd_vld = (stg_cnt != '0);
        wr_acc = io.wr_vld & wr_rdy_q;
        pop    = rd_vld & io.rd_rdy;
        push   = inf_q[DEL-1];
        // The head popped this cycle frees its slot, so streaming holds 1 word/clk.
        occ = 3'(stg_cnt) - 3'(pop);
        for (int i = 0; i < DEL; i++) occ = occ + 3'(inf_q[i]);
        fetch = (ram_cnt_q != '0) && (occ < 3'(DEL + 1));

        wptr_d    = wr_acc ? ADR'(ptr_inc(32'(wptr_q), DEP)) : wptr_q;
        fptr_d    = fetch ? ADR'(ptr_inc(32'(fptr_q), DEP)) : fptr_q;
        level_d   = level_q + LW'(wr_acc) - LW'(pop);
        ram_cnt_d = ram_cnt_q + LW'(wr_acc) - LW'(fetch);
        inf_d     = DEL'({inf_q, fetch});

        wr_rdy_d = (level_d != LW'(DEP));
        afull_d  = (level_d >= LW'(AFUL));
        aempty_d = (level_d <= LW'(AEMP));
        ovf_d    = (io.wr_vld & ~wr_rdy_q) | (ovf_q & ~clr_sticky);
        udf_d    = (io.rd_rdy & ~rd_vld) | (udf_q & ~clr_sticky);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q    <= '0;
            fptr_q    <= '0;
            level_q   <= '0;
            ram_cnt_q <= '0;
            inf_q     <= '0;
            wr_rdy_q  <= 1'b1;
            afull_q   <= 1'b0;
            aempty_q  <= 1'b1;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            fptr_q    <= fptr_d;
            level_q   <= level_d;
            ram_cnt_q <= ram_cnt_d;
            inf_q     <= inf_d;
            wr_rdy_q  <= wr_rdy_d;
            afull_q   <= afull_d;
            aempty_q  <= aempty_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    fifo_stage_reg #(
        .N (SN),
        .W (DAT)
    ) u_stg (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .din  (ram_rdab),
        .pop  (pop),
        .cnt  (stg_cnt),
        .head (stg_head)
    );

    assign io.wr_rdy = wr_rdy_q;
    assign io.rd_vld = rd_vld;
    assign io.rd_dat = stg_head;
    assign level     = level_q;
    assign afull     = afull_q;
    assign aempty    = aempty_q;
    assign ovf       = ovf_q;
    assign udf       = udf_q;
    assign ram_adra  = wptr_q;
    assign ram_wena  = wr_acc;
    assign ram_rena  = wr_acc;
    assign ram_wdaa  = io.wr_dat;
    assign ram_adrb  = fptr_q;
    assign ram_renb  = fetch;

endmodule
